// File: rtl/bisr_fault_log.sv
// bisr_fault_log: logs BIST compare-fail addresses into a spare-entry file and serves remap lookups.
// Latency: a capture is visible one cycle after FAIL_VLD, and LKUP_HIT/LKUP_IDX/DUMP_ADDR are registered (1 cycle).
// Backpressure: none; every FAIL_VLD strobe is handled in its own cycle, and strobes beyond capacity raise REPAIR_FAIL.
//
// Ports:
//   CLK, RST (sync, active-high)      clock and reset
//   LOG_EN, FAIL_VLD, FAIL_ADDR       BIST session enable and fail strobe with its address
//   LOG_CLR                           clears all entries and flags (highest priority)
//   LKUP_ADDR -> LKUP_HIT, LKUP_IDX   registered remap lookup (lowest matching index wins)
//   SPARE_USED, REPAIR_FAIL, REPAIR_RDY  usage count, sticky overflow, repair-ready status
//   DUMP_IDX -> DUMP_ADDR             registered entry readback (0 when the entry is invalid)
// Optional feature: define BISR_DEDUP_EN to drop repeat fault addresses instead of consuming entries.
module bisr_fault_log #(
  parameter int ADDR_W  = 16,
  parameter int SPARE_N = 8,
  localparam int IDX_W  = $clog2(SPARE_N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOG_EN,
  input  logic              FAIL_VLD,
  input  logic [ADDR_W-1:0] FAIL_ADDR,
  input  logic              LOG_CLR,
  input  logic [ADDR_W-1:0] LKUP_ADDR,
  output logic              LKUP_HIT,
  output logic [IDX_W-1:0]  LKUP_IDX,
  output logic [IDX_W:0]    SPARE_USED,
  output logic              REPAIR_FAIL,
  output logic              REPAIR_RDY,
  input  logic [IDX_W-1:0]  DUMP_IDX,
  output logic [ADDR_W-1:0] DUMP_ADDR
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, LOCK} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   entry [SPARE_N];
  logic [SPARE_N-1:0]  valid;
  logic                cap_wr;
  logic                set_fail;
  logic                fail_dup;
  logic                log_full;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [IDX_W-1:0]    wr_idx;

  // Fill pointer equals the usage count; only its low bits are used when not full.
  assign log_full = (SPARE_USED == (IDX_W+1)'(SPARE_N));
  assign wr_idx   = SPARE_USED[IDX_W-1:0];

`ifdef BISR_DEDUP_EN
  // A repeat of any valid entry (including one written last cycle) is dropped.
  always_comb begin
    fail_dup = 1'b0;
    for (int i = 0; i < SPARE_N; i++) begin
      if (valid[i] && (entry[i] == FAIL_ADDR)) fail_dup = 1'b1;
    end
  end
`else
  assign fail_dup = 1'b0;
`endif

  // Parallel lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = SPARE_N-1; i >= 0; i--) begin
      if (valid[i] && (entry[i] == LKUP_ADDR)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cap_wr    = 1'b0;
    set_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (LOG_EN) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (FAIL_VLD && !fail_dup) begin
          if (log_full) begin
            set_fail  = 1'b1;
            state_nxt = FULL;
          end else begin
            cap_wr = 1'b1;
          end
        end
        // Session end wins over the overflow transition; the strobe itself is still honoured.
        if (!LOG_EN) state_nxt = LOCK;
      end
      FULL: begin
        if (!LOG_EN) state_nxt = LOCK;
      end
      LOCK: begin
        if (LOG_EN) state_nxt = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
    if (LOG_CLR) begin
      state_nxt = IDLE;
      cap_wr    = 1'b0;
      set_fail  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      valid       <= '0;
      SPARE_USED  <= '0;
      REPAIR_FAIL <= 1'b0;
      REPAIR_RDY  <= 1'b0;
      LKUP_HIT    <= 1'b0;
      LKUP_IDX    <= '0;
      DUMP_ADDR   <= '0;
      for (int i = 0; i < SPARE_N; i++) entry[i] <= '0;
    end else begin
      state <= state_nxt;
      if (LOG_CLR) begin
        // Entry addresses are left in place; clearing the valid bits hides them everywhere.
        valid       <= '0;
        SPARE_USED  <= '0;
        REPAIR_FAIL <= 1'b0;
        REPAIR_RDY  <= 1'b0;
        LKUP_HIT    <= 1'b0;
        LKUP_IDX    <= '0;
        DUMP_ADDR   <= '0;
      end else begin
        if (cap_wr) begin
          entry[wr_idx] <= FAIL_ADDR;
          valid[wr_idx] <= 1'b1;
          SPARE_USED    <= SPARE_USED + 1'b1;
        end
        if (set_fail) REPAIR_FAIL <= 1'b1;
        REPAIR_RDY <= (state == LOCK) && !REPAIR_FAIL;
        LKUP_HIT   <= lk_hit;
        LKUP_IDX   <= lk_idx;
        DUMP_ADDR  <= valid[DUMP_IDX] ? entry[DUMP_IDX] : '0;
      end
    end
  end

endmodule

// File: tb/tb_bisr_fault_log.sv
// Bench for bisr_fault_log: a queue-based model of the fault log checked every cycle, plus literal expectations.
module tb_bisr_fault_log;

  localparam int N = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOG_EN = 1'b0;
  logic        FAIL_VLD = 1'b0;
  logic [15:0] FAIL_ADDR = '0;
  logic        LOG_CLR = 1'b0;
  logic [15:0] LKUP_ADDR = '0;
  logic        LKUP_HIT;
  logic [2:0]  LKUP_IDX;
  logic [3:0]  SPARE_USED;
  logic        REPAIR_FAIL;
  logic        REPAIR_RDY;
  logic [2:0]  DUMP_IDX = '0;
  logic [15:0] DUMP_ADDR;

  bisr_fault_log #(.ADDR_W(16), .SPARE_N(N)) dut (
    .CLK(CLK), .RST(RST), .LOG_EN(LOG_EN), .FAIL_VLD(FAIL_VLD), .FAIL_ADDR(FAIL_ADDR),
    .LOG_CLR(LOG_CLR), .LKUP_ADDR(LKUP_ADDR), .LKUP_HIT(LKUP_HIT), .LKUP_IDX(LKUP_IDX),
    .SPARE_USED(SPARE_USED), .REPAIR_FAIL(REPAIR_FAIL), .REPAIR_RDY(REPAIR_RDY),
    .DUMP_IDX(DUMP_IDX), .DUMP_ADDR(DUMP_ADDR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the log is a queue of captured addresses; the session phase follows the four named modes.
  localparam int M_IDLE = 0, M_COLLECT = 1, M_FULL = 2, M_LOCK = 3;
  logic [15:0] m_log[$];
  int          m_mode = M_IDLE;
  logic        m_fail = 0, m_rdy = 0, m_hit = 0;
  logic [2:0]  m_idx = 0;
  logic [15:0] m_dump = 0;

  function automatic bit in_log(input logic [15:0] a);
    foreach (m_log[i]) if (m_log[i] == a) return 1;
    return 0;
  endfunction

  always @(posedge CLK) begin
    int          nmode;
    logic        nhit;
    logic [2:0]  nidx;
    bit          dup;
    if (RST || LOG_CLR) begin
      m_log.delete();
      m_mode = M_IDLE;
      m_fail = 0; m_rdy = 0; m_hit = 0; m_idx = 0; m_dump = 0;
    end else begin
      nhit = 0; nidx = 0;
      for (int i = m_log.size() - 1; i >= 0; i--)
        if (m_log[i] == LKUP_ADDR) begin nhit = 1; nidx = 3'(i); end
      m_dump = (int'(DUMP_IDX) < m_log.size()) ? m_log[DUMP_IDX] : 16'h0;
      m_rdy  = (m_mode == M_LOCK) && !m_fail;
      nmode  = m_mode;
      if (m_mode == M_IDLE && LOG_EN) nmode = M_COLLECT;
      if (m_mode == M_LOCK && LOG_EN) nmode = M_COLLECT;
      if (m_mode == M_FULL && !LOG_EN) nmode = M_LOCK;
      if (m_mode == M_COLLECT) begin
`ifdef BISR_DEDUP_EN
        dup = in_log(FAIL_ADDR);
`else
        dup = 0;
`endif
        if (FAIL_VLD && !dup) begin
          if (m_log.size() < N) m_log.push_back(FAIL_ADDR);
          else begin m_fail = 1; nmode = M_FULL; end
        end
        if (!LOG_EN) nmode = M_LOCK;
      end
      m_mode = nmode;
      m_hit = nhit; m_idx = nidx;
    end
    #1;
    chk("model_used", 32'(SPARE_USED), 32'(m_log.size()));
    chk("model_repair_fail", 32'(REPAIR_FAIL), 32'(m_fail));
    chk("model_repair_rdy", 32'(REPAIR_RDY), 32'(m_rdy));
    chk("model_lkup_hit", 32'(LKUP_HIT), 32'(m_hit));
    if (m_hit) chk("model_lkup_idx", 32'(LKUP_IDX), 32'(m_idx));
    chk("model_dump_addr", 32'(DUMP_ADDR), 32'(m_dump));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic strobe(input logic [15:0] a);
    FAIL_VLD = 1; FAIL_ADDR = a;
    tick();
    FAIL_VLD = 0;
  endtask

  initial begin
    tick(2);
    RST = 0;
    tick();
    chk("reset_used", 32'(SPARE_USED), 0);
    chk("reset_fail", 32'(REPAIR_FAIL), 0);
    chk("reset_rdy", 32'(REPAIR_RDY), 0);
    chk("reset_hit", 32'(LKUP_HIT), 0);
    chk("reset_dump", 32'(DUMP_ADDR), 0);

    // Three captures, the last coinciding with LOG_EN falling.
    LOG_EN = 1; tick();
    strobe(16'h0C05);
    strobe(16'h1000);
    LOG_EN = 0; strobe(16'hFFFF);
    chk("used_after_3", 32'(SPARE_USED), 3);
    tick();
    chk("rdy_in_lock", 32'(REPAIR_RDY), 1);
    strobe(16'h7777);
    chk("lock_ignores_fail", 32'(SPARE_USED), 3);
    DUMP_IDX = 0; tick(); chk("dump0", 32'(DUMP_ADDR), 32'h0C05);
    DUMP_IDX = 1; tick(); chk("dump1", 32'(DUMP_ADDR), 32'h1000);
    DUMP_IDX = 2; tick(); chk("dump2", 32'(DUMP_ADDR), 32'hFFFF);
    DUMP_IDX = 3; tick(); chk("dump3_invalid", 32'(DUMP_ADDR), 0);

    LKUP_ADDR = 16'h1000; tick();
    chk("lkup_1000_hit", 32'(LKUP_HIT), 1);
    chk("lkup_1000_idx", 32'(LKUP_IDX), 1);
    LKUP_ADDR = 16'h1001; tick();
    chk("lkup_1001_miss", 32'(LKUP_HIT), 0);

    // Resume: append after existing entries; no write-to-lookup bypass.
    LOG_EN = 1; tick();
    LKUP_ADDR = 16'h0040; strobe(16'h0040);
    chk("no_bypass_miss", 32'(LKUP_HIT), 0);
    tick();
    chk("next_cycle_hit", 32'(LKUP_HIT), 1);
    chk("next_cycle_idx", 32'(LKUP_IDX), 3);
    strobe(16'h0500);
    chk("used_5", 32'(SPARE_USED), 5);

    // Clear collides with a strobe: nothing written, mode returns to idle.
    LOG_EN = 0; LOG_CLR = 1; strobe(16'h0777);
    LOG_CLR = 0;
    chk("clr_used", 32'(SPARE_USED), 0);
    chk("clr_fail", 32'(REPAIR_FAIL), 0);
    chk("clr_hit", 32'(LKUP_HIT), 0);
    DUMP_IDX = 5; strobe(16'h0888);
    chk("idle_ignores_fail", 32'(SPARE_USED), 0);
    chk("clr_dump5", 32'(DUMP_ADDR), 0);

    // Overflow: nine distinct strobes into eight spares.
    LOG_EN = 1; tick();
    for (int i = 0; i < 9; i++) strobe(16'h0100 + 16'(i));
    chk("ovf_used", 32'(SPARE_USED), 8);
    chk("ovf_fail", 32'(REPAIR_FAIL), 1);
    strobe(16'h0999);
    chk("full_ignores_fail", 32'(SPARE_USED), 8);
    LOG_EN = 0; tick(2);
    chk("ovf_rdy_low", 32'(REPAIR_RDY), 0);
    DUMP_IDX = 7; LKUP_ADDR = 16'h0108; tick();
    chk("ovf_dump7", 32'(DUMP_ADDR), 32'h0107);
    chk("ovf_9th_miss", 32'(LKUP_HIT), 0);

    // Repeated address on consecutive cycles.
    LOG_CLR = 1; tick(); LOG_CLR = 0;
    LOG_EN = 1; tick();
    FAIL_VLD = 1; FAIL_ADDR = 16'h0203; tick(3); FAIL_VLD = 0;
    LKUP_ADDR = 16'h0203; tick();
`ifdef BISR_DEDUP_EN
    chk("dup_used", 32'(SPARE_USED), 1);
`else
    chk("dup_used", 32'(SPARE_USED), 3);
`endif
    chk("dup_lkup_idx", 32'(LKUP_IDX), 0);
    LOG_EN = 0; tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bisr_fault_log.md
# bisr_fault_log

Built-in self-repair fault logger that sits directly downstream of the memory BIST sequencer. It captures the 16-bit address (6-bit bank select + 10-bit word address) of every compare failure the BIST reports and stores it in a small spare-entry register file. After the test it provides a registered remap lookup, so the memory controller can steer functional accesses to spare words. It also reports spare usage and an irreparable-overflow flag.

## Interface
- ADDR_W, 16, fault address width; bits [15:10] are the bank, bits [9:0] are the word.
- SPARE_N, 8, number of spare entries; must be a power of two, 2..16.
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- LOG_EN  input  1  BIST session active; enables fault capture.
- FAIL_VLD  input  1  one-cycle BIST compare-fail strobe.
- FAIL_ADDR  input  ADDR_W  address of the failing access; valid only with FAIL_VLD.
- LOG_CLR  input  1  synchronous clear of all entries and flags.
- LKUP_ADDR  input  ADDR_W  functional access address to check against the log.
- LKUP_HIT  output  1  registered: LKUP_ADDR matches a valid entry.
- LKUP_IDX  output  log2(SPARE_N)  registered: index of the matching entry (lowest index wins).
- SPARE_USED  output  log2(SPARE_N)+1  number of valid entries.
- REPAIR_FAIL  output  1  sticky: a new fault arrived with all entries used.
- REPAIR_RDY  output  1  high in LOCK with REPAIR_FAIL low.
- DUMP_IDX  input  log2(SPARE_N)  entry select for readback.
- DUMP_ADDR  output  ADDR_W  registered address of entry DUMP_IDX; returns 0 if the entry is invalid.

## Operation
- Storage: SPARE_N address registers plus a valid bit per entry. Entries fill in index order from 0; the fill pointer equals SPARE_USED.
- FSM states: IDLE, COLLECT, FULL, LOCK.
  - IDLE: on LOG_EN=1, go to COLLECT.
  - COLLECT: on FAIL_VLD, write FAIL_ADDR to entry[SPARE_USED], set its valid bit, and increment SPARE_USED. If FAIL_VLD arrives with SPARE_USED==SPARE_N, set REPAIR_FAIL and go to FULL. On LOG_EN=0, go to LOCK.
  - FULL: FAIL_VLD is ignored and no entries are written. On LOG_EN=0, go to LOCK.
  - LOCK: entries are frozen and FAIL_VLD is ignored. On LOG_EN=1, go to COLLECT; existing entries are kept and logging appends after them.
- LOG_CLR, in any state, has priority over every other input: all valid bits, SPARE_USED and REPAIR_FAIL go to 0 and the FSM goes to IDLE next cycle.
- Lookup is active in every state and compares LKUP_ADDR against all valid entries in parallel.
- Reset values: FSM=IDLE, all valid bits 0, all entry addresses 0, LKUP_HIT=0, LKUP_IDX=0, SPARE_USED=0, REPAIR_FAIL=0, REPAIR_RDY=0, DUMP_ADDR=0.

## Timing
- Capture latency: with FAIL_VLD at cycle N, the entry is valid and SPARE_USED is updated at cycle N+1.
- FAIL_VLD may assert on consecutive cycles; each strobe is one fault, with no backpressure.
- Lookup latency: LKUP_HIT, LKUP_IDX and DUMP_ADDR are registered, so they reflect inputs from cycle N at cycle N+1.
- No write-to-lookup bypass: a lookup in the same cycle as a capture of that address misses; a lookup one cycle later hits.
- Same cycle as the LOG_EN 1→0 transition: a FAIL_VLD in that cycle is still captured if the FSM is in COLLECT.
- RST or LOG_CLR asserted mid-session: flags and outputs are cleared the next cycle. Registered outputs show the cleared state from cycle N+1.
- REPAIR_RDY is a registered function of the FSM state and REPAIR_FAIL.

## Configuration
- BISR_DEDUP_EN defined:
  - Before writing, FAIL_ADDR is compared against all valid entries. On a match, nothing is written and SPARE_USED is unchanged.
  - A duplicate arriving when the log is full does not set REPAIR_FAIL.
  - A duplicate of an entry written in the previous cycle is also detected, because the entry is already valid.
- BISR_DEDUP_EN undefined:
  - Every FAIL_VLD consumes an entry, including repeats. This saves the compare logic.
  - REPAIR_FAIL sets on the (SPARE_N+1)th strobe.

## Test plan
- Reset, then LOG_EN=1 and FAIL_VLD with 16'h0C05, 16'h1000, 16'hFFFF, then LOG_EN=0 → SPARE_USED=3, FSM in LOCK, REPAIR_RDY=1, DUMP_IDX 0/1/2 → DUMP_ADDR 0C05/1000/FFFF; DUMP_IDX 3 → 0.
- In LOCK, LKUP_ADDR=16'h1000 → LKUP_HIT=1, LKUP_IDX=1 one cycle later; LKUP_ADDR=16'h1001 → LKUP_HIT=0.
- Nine distinct FAIL_VLD strobes with SPARE_N=8 → SPARE_USED=8, REPAIR_FAIL=1, FSM in FULL; after LOG_EN=0, REPAIR_RDY=0 and entry 7 holds the 8th address.
- With BISR_DEDUP_EN, 16'h0203 strobed on three consecutive cycles → SPARE_USED=1. Without the macro → SPARE_USED=3.
- Capture 16'h0040 and set LKUP_ADDR=16'h0040 in the same cycle → LKUP_HIT=0 next cycle; hold LKUP_ADDR → LKUP_HIT=1 the following cycle.
- LOG_CLR asserted together with FAIL_VLD while in COLLECT with SPARE_USED=5 → next cycle SPARE_USED=0, REPAIR_FAIL=0, FSM in IDLE, and no entry written.
